per2axi_res_channel: RTL and testbench

- Response-side companion of the per2axi request channel.
- Consumes AXI R and B beats plus the trans/atop bookkeeping pulses from the request stage, and returns exactly one peripheral-interconnect response per request.
- Keeps a per-ID table holding the address lane and atomic state, so 64-bit read data is narrowed to the correct 32-bit word.
- Merges the R and B beats of an atomic (ATOP) transaction into a single response.

---
 rtl/per2axi_pkg.sv | 36 +++
 rtl/per2axi_res_tracker.sv | 71 +++++++
 rtl/per2axi_res_channel.sv | 167 ++++++++++++++++
 tb/tb_per2axi_res_channel.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/per2axi_pkg.sv
// Shared types and helpers for the per2axi response path.
// Holds AXI response codes, the per-ID table entry and the 64->32 lane narrowing.
package per2axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        rd_pend;
    logic        at_pend;
    logic        lane;
    logic        got_r;
    logic        got_b;
    logic        err;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    UPD_CLR_RD,
    UPD_CLR_ALL,
    UPD_STORE_R,
    UPD_STORE_B
  } upd_op_e;

  function automatic logic [31:0] lane_select(input logic [63:0] data, input logic lane);
    return lane ? data[63:32] : data[31:0];
  endfunction

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/per2axi_res_tracker.sv
// Per-AXI-ID bookkeeping table: pending flags, address lane and partial ATOP state.
// Updates from the response side are applied first so a same-cycle request set overrides them.
module per2axi_res_tracker
  import per2axi_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      set_rd_i,
  input  logic [AXI_ID_WIDTH-1:0]   set_rd_id_i,
  input  logic                      set_rd_lane_i,
  input  logic                      set_at_i,
  input  logic [AXI_ID_WIDTH-1:0]   set_at_id_i,
  input  logic                      set_at_lane_i,
  input  logic                      upd_i,
  input  upd_op_e                   upd_op_i,
  input  logic [AXI_ID_WIDTH-1:0]   upd_id_i,
  input  logic [31:0]               upd_data_i,
  input  logic                      upd_err_i,
  input  logic [AXI_ID_WIDTH-1:0]   rd_id_i,
  output entry_t                    rd_entry_o,
  output logic [2**AXI_ID_WIDTH-1:0] pend_o
);

  localparam int unsigned N_ENTRIES = 2**AXI_ID_WIDTH;

  entry_t r_tab [N_ENTRIES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) r_tab[i] <= '0;
    end else begin
      if (upd_i) begin
        case (upd_op_i)
          UPD_CLR_RD:  r_tab[upd_id_i].rd_pend <= 1'b0;
          UPD_CLR_ALL: r_tab[upd_id_i]         <= '0;
          UPD_STORE_R: begin
            r_tab[upd_id_i].data  <= upd_data_i;
            r_tab[upd_id_i].err   <= r_tab[upd_id_i].err | upd_err_i;
            r_tab[upd_id_i].got_r <= 1'b1;
          end
          UPD_STORE_B: begin
            r_tab[upd_id_i].err   <= r_tab[upd_id_i].err | upd_err_i;
            r_tab[upd_id_i].got_b <= 1'b1;
          end
          default: ;
        endcase
      end
      if (set_rd_i) begin
        r_tab[set_rd_id_i].rd_pend <= 1'b1;
        r_tab[set_rd_id_i].lane    <= set_rd_lane_i;
      end
      if (set_at_i) begin
        r_tab[set_at_id_i].at_pend <= 1'b1;
        r_tab[set_at_id_i].lane    <= set_at_lane_i;
        r_tab[set_at_id_i].got_r   <= 1'b0;
        r_tab[set_at_id_i].got_b   <= 1'b0;
        r_tab[set_at_id_i].err     <= 1'b0;
      end
    end
  end

  assign rd_entry_o = r_tab[rd_id_i];

  always_comb begin
    pend_o = '0;
    for (int i = 0; i < N_ENTRIES; i++) pend_o[i] = r_tab[i].rd_pend | r_tab[i].at_pend;
  end

endmodule

// File: rtl/per2axi_res_channel.sv
// Response side of per2axi: accepts one R or B beat per cycle (R first) and
// returns a single registered peripheral response per request, merging ATOP R+B pairs.
module per2axi_res_channel
  import per2axi_pkg::*;
#(
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,
  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o,
  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,
  input  logic                      trans_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  input  logic                      atop_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   atop_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] atop_add_i
);

  logic                      w_r_acc;
  logic                      w_b_acc;
  logic [AXI_ID_WIDTH-1:0]   w_rd_id;
  entry_t                    w_ent;
  logic [2**AXI_ID_WIDTH-1:0] w_pend;
  logic [31:0]               w_r_lane_data;
  logic                      w_resp_valid;
  logic                      w_resp_opc;
  logic [31:0]               w_resp_data;
  logic                      w_upd;
  upd_op_e                   w_upd_op;
  logic                      w_upd_err;
  logic                      w_unused;

  logic                      r_valid;
  logic                      r_opc;
  logic [PER_ID_WIDTH-1:0]   r_id;
  logic [31:0]               r_rdata;

  assign axi_master_r_ready_o = !rst_i;
  assign axi_master_b_ready_o = !rst_i && !axi_master_r_valid_i;

  assign w_r_acc = axi_master_r_valid_i && axi_master_r_ready_o;
  assign w_b_acc = axi_master_b_valid_i && axi_master_b_ready_o;
  assign w_rd_id = w_r_acc ? axi_master_r_id_i : axi_master_b_id_i;
  assign w_r_lane_data = lane_select(axi_master_r_data_i, w_ent.lane);

  assign w_unused = ^{axi_master_r_user_i, axi_master_b_user_i, trans_add_i, atop_add_i};

  per2axi_res_tracker #(
    .AXI_ID_WIDTH (AXI_ID_WIDTH)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .set_rd_i      (trans_req_i),
    .set_rd_id_i   (trans_id_i),
    .set_rd_lane_i (trans_add_i[2]),
    .set_at_i      (atop_req_i),
    .set_at_id_i   (atop_id_i),
    .set_at_lane_i (atop_add_i[2]),
    .upd_i         (w_upd),
    .upd_op_i      (w_upd_op),
    .upd_id_i      (w_rd_id),
    .upd_data_i    (w_r_lane_data),
    .upd_err_i     (w_upd_err),
    .rd_id_i       (w_rd_id),
    .rd_entry_o    (w_ent),
    .pend_o        (w_pend)
  );

  always_comb begin
    w_resp_valid = 1'b0;
    w_resp_opc   = 1'b0;
    w_resp_data  = '0;
    w_upd        = 1'b0;
    w_upd_op     = UPD_CLR_RD;
    w_upd_err    = 1'b0;
    if (w_r_acc) begin
      w_upd_err = resp_is_err(axi_master_r_resp_i);
      w_upd     = 1'b1;
      if (!w_ent.at_pend) begin
        w_resp_valid = 1'b1;
        w_resp_data  = w_r_lane_data;
        w_resp_opc   = resp_is_err(axi_master_r_resp_i);
        w_upd_op     = UPD_CLR_RD;
      end else if (!w_ent.got_b) begin
        w_upd_op     = UPD_STORE_R;
      end else begin
        w_resp_valid = 1'b1;
        w_resp_data  = w_r_lane_data;
        w_resp_opc   = resp_is_err(axi_master_r_resp_i) | w_ent.err;
        w_upd_op     = UPD_CLR_ALL;
      end
    end else if (w_b_acc) begin
      w_upd_err = resp_is_err(axi_master_b_resp_i);
      if (!w_ent.at_pend) begin
        w_resp_valid = 1'b1;
        w_resp_opc   = resp_is_err(axi_master_b_resp_i);
      end else if (!w_ent.got_r) begin
        w_upd        = 1'b1;
        w_upd_op     = UPD_STORE_B;
      end else begin
        w_resp_valid = 1'b1;
        w_resp_data  = w_ent.data;
        w_resp_opc   = resp_is_err(axi_master_b_resp_i) | w_ent.err;
        w_upd        = 1'b1;
        w_upd_op     = UPD_CLR_ALL;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_opc   <= 1'b0;
      r_id    <= '0;
      r_rdata <= '0;
    end else begin
      r_valid <= w_resp_valid;
      if (w_resp_valid) begin
        r_opc   <= w_resp_opc;
        r_id    <= PER_ID_WIDTH'(1) << w_rd_id;
        r_rdata <= w_resp_data;
      end
    end
  end

  assign per_slave_r_valid_o = r_valid;
  assign per_slave_r_opc_o   = r_opc;
  assign per_slave_r_id_o    = r_id;
  assign per_slave_r_rdata_o = r_rdata;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_r_acc) begin
        assert (w_ent.rd_pend || w_ent.at_pend)
          else $error("R beat for ID %0d with nothing pending", axi_master_r_id_i);
        assert (axi_master_r_last_i)
          else $error("R beat without last");
      end
      if (trans_req_i)
        assert (!w_pend[trans_id_i]) else $error("read issued to pending ID %0d", trans_id_i);
      if (atop_req_i)
        assert (!w_pend[atop_id_i]) else $error("ATOP issued to pending ID %0d", atop_id_i);
    end
  end
`endif

endmodule

// File: tb/tb_per2axi_res_channel.sv
// Scoreboard bench for per2axi_res_channel: tasks queue expected responses,
// a negedge monitor pops and compares whenever a response pulse appears.
module tb_per2axi_res_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_valid_o, r_opc_o;
  logic [4:0]  r_id_o;
  logic [31:0] r_rdata_o;
  logic        ar_valid;
  logic [63:0] ar_data;
  logic [1:0]  ar_resp;
  logic        ar_last;
  logic [2:0]  ar_id;
  logic [5:0]  ar_user;
  logic        ar_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  logic [5:0]  b_user;
  logic        b_ready;
  logic        t_req;
  logic [2:0]  t_id;
  logic [31:0] t_add;
  logic        a_req;
  logic [2:0]  a_id;
  logic [31:0] a_add;

  always #5 clk = ~clk;

  per2axi_res_channel dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .per_slave_r_valid_o  (r_valid_o),
    .per_slave_r_opc_o    (r_opc_o),
    .per_slave_r_id_o     (r_id_o),
    .per_slave_r_rdata_o  (r_rdata_o),
    .axi_master_r_valid_i (ar_valid),
    .axi_master_r_data_i  (ar_data),
    .axi_master_r_resp_i  (ar_resp),
    .axi_master_r_last_i  (ar_last),
    .axi_master_r_id_i    (ar_id),
    .axi_master_r_user_i  (ar_user),
    .axi_master_r_ready_o (ar_ready),
    .axi_master_b_valid_i (b_valid),
    .axi_master_b_resp_i  (b_resp),
    .axi_master_b_id_i    (b_id),
    .axi_master_b_user_i  (b_user),
    .axi_master_b_ready_o (b_ready),
    .trans_req_i          (t_req),
    .trans_id_i           (t_id),
    .trans_add_i          (t_add),
    .atop_req_i           (a_req),
    .atop_id_i            (a_id),
    .atop_add_i           (a_add)
  );

  typedef struct packed {
    logic        opc;
    logic [4:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (r_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got opc=%b id=%b data=%h, none expected", r_opc_o, r_id_o, r_rdata_o);
      end else begin
        m_e = exp_q.pop_front();
        if ({r_opc_o, r_id_o, r_rdata_o} !== m_e) begin
          errors++;
          $display("FAIL resp got opc=%b id=%b data=%h required opc=%b id=%b data=%h",
                   r_opc_o, r_id_o, r_rdata_o, m_e.opc, m_e.id, m_e.data);
        end
      end
    end
  end

  task automatic issue_trans(input logic [2:0] id, input logic [31:0] addr);
    @(negedge clk); t_req = 1'b1; t_id = id; t_add = addr;
    @(negedge clk); t_req = 1'b0;
  endtask

  task automatic issue_atop(input logic [2:0] id, input logic [31:0] addr);
    @(negedge clk); a_req = 1'b1; a_id = id; a_add = addr;
    @(negedge clk); a_req = 1'b0;
  endtask

  task automatic send_r(input logic [2:0] id, input logic [63:0] data, input logic [1:0] resp);
    @(negedge clk); ar_valid = 1'b1; ar_id = id; ar_data = data; ar_resp = resp; ar_last = 1'b1;
    @(negedge clk); ar_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] id, input logic [1:0] resp);
    @(negedge clk); b_valid = 1'b1; b_id = id; b_resp = resp;
    @(negedge clk); b_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", r_valid_o); end
    checks++; if (r_opc_o !== 1'b0) begin errors++; $display("FAIL reset_opc got %b required 0", r_opc_o); end
    checks++; if (r_id_o !== 5'b0) begin errors++; $display("FAIL reset_id got %b required 0", r_id_o); end
    checks++; if (r_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h required 0", r_rdata_o); end
    checks++; if (ar_ready !== 1'b0) begin errors++; $display("FAIL reset_r_ready got %b required 0", ar_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %b required 0", b_ready); end
    rst = 1'b0;
    #1;
    checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL run_r_ready got %b required 1", ar_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL run_b_ready got %b required 1", b_ready); end
    ar_valid = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b_ready_blocked got %b required 0", b_ready); end
    ar_valid = 1'b0;
  endtask

  task automatic test_read;
    issue_trans(3'd2, 32'h1004);
    exp_q.push_back('{1'b0, 5'b00100, 32'hAAAA_BBBB});
    send_r(3'd2, 64'hAAAA_BBBB_1111_2222, 2'b00);
    issue_trans(3'd4, 32'h2000);
    exp_q.push_back('{1'b1, 5'b10000, 32'h9ABC_DEF0});
    send_r(3'd4, 64'h1234_5678_9ABC_DEF0, 2'b10);
    issue_trans(3'd1, 32'h0000_0004);
    exp_q.push_back('{1'b1, 5'b00010, 32'hCAFE_F00D});
    send_r(3'd1, 64'hCAFE_F00D_0BAD_BEEF, 2'b11);
    issue_trans(3'd0, 32'h0000_0000);
    exp_q.push_back('{1'b0, 5'b00001, 32'h0000_0002});
    send_r(3'd0, 64'h0000_0001_0000_0002, 2'b01);
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_write;
    exp_q.push_back('{1'b1, 5'b00001, 32'h0});
    send_b(3'd0, 2'b10);
    exp_q.push_back('{1'b0, 5'b00010, 32'h0});
    send_b(3'd1, 2'b00);
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL write_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_atop_r_first;
    issue_atop(3'd3, 32'h0);
    send_r(3'd3, 64'h0000_0009_0000_0005, 2'b00);
    for (int i = 0; i < 3; i++) begin
      checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL atop_r_no_resp got %b required 0", r_valid_o); end
      @(negedge clk);
    end
    exp_q.push_back('{1'b0, 5'b01000, 32'h5});
    send_b(3'd3, 2'b00);
    issue_atop(3'd3, 32'h4);
    send_r(3'd3, 64'h0000_0077_0000_0011, 2'b10);
    checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL atop_r_lane1_no_resp got %b required 0", r_valid_o); end
    exp_q.push_back('{1'b1, 5'b01000, 32'h77});
    send_b(3'd3, 2'b00);
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL atop_r_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_atop_b_first;
    issue_atop(3'd1, 32'h104);
    send_b(3'd1, 2'b10);
    checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL atop_b_no_resp got %b required 0", r_valid_o); end
    exp_q.push_back('{1'b1, 5'b00010, 32'hDEAD_BEEF});
    send_r(3'd1, 64'hDEAD_BEEF_0000_0000, 2'b00);
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL atop_b_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back;
    issue_trans(3'd2, 32'h0);
    @(negedge clk);
    ar_valid = 1'b1; ar_id = 3'd2; ar_data = 64'h5555_6666_7777_8888; ar_resp = 2'b00; ar_last = 1'b1;
    b_valid = 1'b1; b_id = 3'd4; b_resp = 2'b10;
    exp_q.push_back('{1'b0, 5'b00100, 32'h7777_8888});
    exp_q.push_back('{1'b1, 5'b10000, 32'h0});
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL b2b_b_ready got %b required 0", b_ready); end
    checks++; if (ar_ready !== 1'b1) begin errors++; $display("FAIL b2b_r_ready got %b required 1", ar_ready); end
    @(negedge clk);
    ar_valid = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_b_ready_after got %b required 1", b_ready); end
    @(negedge clk);
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid;
    issue_atop(3'd3, 32'h0);
    send_r(3'd3, 64'h0000_0000_0000_0005, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b required 0", r_valid_o); end
    rst = 1'b0;
    exp_q.push_back('{1'b0, 5'b01000, 32'h0});
    send_b(3'd3, 2'b00);
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reset_drain got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    rst = 1'b1;
    ar_valid = 1'b0; ar_data = '0; ar_resp = '0; ar_last = 1'b1; ar_id = '0; ar_user = 6'h2A;
    b_valid = 1'b0; b_resp = '0; b_id = '0; b_user = 6'h15;
    t_req = 1'b0; t_id = '0; t_add = '0;
    a_req = 1'b0; a_id = '0; a_add = '0;
    test_reset();
    test_read();
    test_write();
    test_atop_r_first();
    test_atop_b_first();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
